// File: rtl/usb_rx_pkt_pkg.sv
// Shared PID codes, FSM encoding and CRC16 constants for the USB packet receiver.
// Combinational helpers only; no state lives here.
package usb_rx_pkg;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  localparam logic [15:0] CRC_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC_POLY     = 16'hA001;
  localparam logic [15:0] CRC_RESIDUAL = 16'hB001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PID   = 3'd1,
    ST_DATA  = 3'd2,
    ST_HS    = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic logic pid_is_data(input logic [3:0] p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction

endpackage

// File: rtl/usb_rx_pkt_if.sv
// Byte stream from the UTMI-style receiver in, decoded payload and packet status out.
// Receive side has no backpressure; the consumer must take data_valid strobes as they come.
interface usb_rx_pkt_if;
  logic       rx_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_error;
  logic [3:0] pid;
  logic [7:0] data_out;
  logic       data_valid;
  logic       pkt_done;
  logic       crc_ok;
  logic       pkt_err;
  logic [6:0] pkt_len;
  logic       busy;

  modport master (
    output rx_active, rx_valid, rx_data, rx_error,
    input  pid, data_out, data_valid, pkt_done, crc_ok, pkt_err, pkt_len, busy
  );

  modport slave (
    input  rx_active, rx_valid, rx_data, rx_error,
    output pid, data_out, data_valid, pkt_done, crc_ok, pkt_err, pkt_len, busy
  );
endinterface

// File: rtl/usb_rx_pkt_crc16.sv
// One byte of reflected CRC16 (LSB first), purely combinational.
// Zero latency; no flow control.
module usb_crc16_byte
  import usb_rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);
  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, byte_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end
endmodule

// File: rtl/usb_rx_pkt.sv
// USB packet receiver: PID check, CRC16 verify, payload with the two CRC bytes stripped.
// Payload appears two bytes behind the wire; status is registered at DONE; no backpressure.
module usb_rx_pkt
  import usb_rx_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64
) (
  input logic          clk,
  input logic          reset,
  usb_rx_pkt_if.slave  bus
);
  localparam int CW = $clog2(MAX_PAYLOAD + 3) + 1;

  state_t state, next_state;

  logic          active_q;
  logic [CW-1:0] nbytes;
  logic [7:0]    hold_old, hold_new;
  logic [15:0]   crc, crc_next;
  logic [6:0]    len;
  logic [3:0]    pid_r;
  logic [7:0]    data_out_r;
  logic          data_valid_r, crc_ok_r, pkt_err_r;
  logic [6:0]    pkt_len_r;

  logic rise, pid_ok, ovf, short_pkt;
  logic busy_c, done_c, push, emit, fin_err, fin_crc_ok;

  assign rise      = bus.rx_active & ~active_q;
  assign pid_ok    = (bus.rx_data[7:4] == ~bus.rx_data[3:0]);
  assign ovf       = (nbytes == CW'(MAX_PAYLOAD + 2));
  assign short_pkt = (nbytes < CW'(2));

  usb_crc16_byte u_crc (
    .crc_in  (crc),
    .byte_in (bus.rx_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (rise) next_state = ST_PID;
      ST_PID: begin
        if (bus.rx_error)       next_state = ST_DRAIN;
        else if (bus.rx_valid)  next_state = !pid_ok ? ST_DRAIN :
                                             (pid_is_data(bus.rx_data[3:0]) ? ST_DATA : ST_HS);
        else if (!bus.rx_active) next_state = ST_DONE;
      end
      ST_DATA: begin
        if (bus.rx_error)                        next_state = ST_DRAIN;
        else if (bus.rx_valid && ovf)            next_state = ST_DRAIN;
        else if (!bus.rx_valid && !bus.rx_active) next_state = ST_DONE;
      end
      ST_HS: begin
        if (bus.rx_error)        next_state = ST_DRAIN;
        else if (!bus.rx_active) next_state = ST_DONE;
      end
      ST_DRAIN: if (!bus.rx_active) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // fin_* describe the packet outcome as seen from the state that exits into DONE.
  always_comb begin
    busy_c     = (state != ST_IDLE);
    done_c     = (state == ST_DONE);
    push       = (state == ST_DATA) && bus.rx_valid && !bus.rx_error && !ovf;
    emit       = push && !short_pkt;
    fin_err    = 1'b0;
    fin_crc_ok = 1'b0;
    case (state)
      ST_PID:   fin_err = 1'b1;
      ST_DATA: begin
        fin_err    = short_pkt;
        fin_crc_ok = !short_pkt && (crc == CRC_RESIDUAL);
      end
      ST_HS:    fin_crc_ok = 1'b1;
      ST_DRAIN: fin_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // Treat the line as already active so a packet in flight at reset is not picked up mid-way.
      active_q     <= 1'b1;
      nbytes       <= '0;
      hold_old     <= '0;
      hold_new     <= '0;
      crc          <= CRC_INIT;
      len          <= '0;
      pid_r        <= '0;
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
      crc_ok_r     <= 1'b0;
      pkt_err_r    <= 1'b0;
      pkt_len_r    <= '0;
    end else begin
      active_q     <= bus.rx_active;
      data_valid_r <= emit;
      if (state == ST_IDLE) begin
        nbytes   <= '0;
        hold_old <= '0;
        hold_new <= '0;
        crc      <= CRC_INIT;
        len      <= '0;
      end
      if (state == ST_PID && bus.rx_valid && !bus.rx_error && pid_ok)
        pid_r <= bus.rx_data[3:0];
      if (push) begin
        nbytes   <= nbytes + CW'(1);
        crc      <= crc_next;
        hold_old <= hold_new;
        hold_new <= bus.rx_data;
      end
      if (emit) begin
        data_out_r <= hold_old;
        if (len != 7'(MAX_PAYLOAD)) len <= len + 7'd1;
      end
      if (next_state == ST_DONE && state != ST_DONE) begin
        pkt_err_r <= fin_err;
        crc_ok_r  <= fin_crc_ok & ~fin_err;
        pkt_len_r <= len;
      end
    end
  end

  assign bus.pid        = pid_r;
  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;
  assign bus.pkt_done   = done_c;
  assign bus.crc_ok     = crc_ok_r;
  assign bus.pkt_err    = pkt_err_r;
  assign bus.pkt_len    = pkt_len_r;
  assign bus.busy       = busy_c;
endmodule

// File: doc/usb_rx_pkt.md
USB_RX_PKT -- requirements
Module: usb_rx_pkt

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 64, max data bytes accepted per packet (excl. PID, CRC).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port rx_active  input  1  high for the duration of a received packet.
REQ-005 SHALL have port rx_valid  input  1  rx_data holds a valid byte this cycle.
REQ-006 SHALL have port rx_data  input  8  received byte, LSB first on the wire.
REQ-007 SHALL have port rx_error  input  1  line-level receive error (bit-stuff or sync).
REQ-008 SHALL have port pid  output  4  PID of the current/last packet.
REQ-009 SHALL have port data_out  output  8  payload byte, CRC bytes stripped.
REQ-010 SHALL have port data_valid  output  1  one-cycle strobe qualifying data_out.
REQ-011 SHALL have port pkt_done  output  1  one-cycle end-of-packet strobe.
REQ-012 SHALL have port crc_ok  output  1  CRC16 residual matched; valid with pkt_done.
REQ-013 SHALL have port pkt_err  output  1  PID, length, overflow or line error; valid with pkt_done.
REQ-014 SHALL have port pkt_len  output  7  payload byte count; valid with pkt_done.
REQ-015 SHALL have port busy  output  1  FSM not in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, PID, DATA, HS, DRAIN, DONE.
REQ-017 IDLE SHALL move to PID only on a rising edge of rx_active (low last cycle, high this cycle).
REQ-018 PID: the first rx_valid byte SHALL be checked as rx_data[7:4] == ~rx_data[3:0]; on pass, pid <= rx_data[3:0].
REQ-019 PID check fail SHALL set pkt_err and move to DRAIN.
REQ-020 DATA0 (0011) and DATA1 (1011) SHALL move to DATA; every other valid PID SHALL move to HS.
REQ-021 HS SHALL ignore further bytes; on rx_active low -> DONE with pkt_len=0, crc_ok=1, pkt_err=0.
REQ-022 DATA SHALL push each rx_valid byte into a 2-byte holding register; data_out/data_valid SHALL be emitted only when a third byte pushes the oldest out.
REQ-023 data_valid SHALL be registered: asserted the cycle after the rx_valid cycle that caused the push.
REQ-024 The two held bytes at end of packet SHALL be treated as CRC and never emitted.
REQ-025 CRC16 SHALL use the reflected form: poly 16'hA001, init 16'hFFFF, LSB first, over all DATA-state bytes including the CRC bytes.
REQ-026 crc_ok SHALL be 1 iff the final register equals 16'hB001.
REQ-027 pkt_len SHALL count emitted bytes and saturate at MAX_PAYLOAD.
REQ-028 An (MAX_PAYLOAD+3)-th byte in DATA SHALL set pkt_err and move to DRAIN.
REQ-029 rx_active falling in DATA with fewer than 2 bytes received SHALL set pkt_err (short packet).
REQ-030 rx_error high while busy SHALL set pkt_err and move to DRAIN, overriding a same-cycle rx_valid byte.
REQ-031 rx_active falling in PID before any byte SHALL set pkt_err.
REQ-032 DRAIN SHALL discard bytes until rx_active is low, then move to DONE.
REQ-033 DONE SHALL assert pkt_done for exactly one cycle, with crc_ok forced to 0 when pkt_err=1, then return to IDLE.
REQ-034 Status outputs SHALL hold their values until the next pkt_done.

Reset
REQ-035 While reset=0 at a clk edge: state=IDLE; data_valid, pkt_done, pkt_err, crc_ok, busy=0; pid=0, data_out=0, pkt_len=0; CRC register = 16'hFFFF; holding register cleared.
REQ-036 Reset mid-packet SHALL abandon the packet with no pkt_done; with rx_active still high, no new packet SHALL start before rx_active goes low (REQ-017).

Structure
REQ-037 Package usb_rx_pkg SHALL hold the PID codes, state encoding, CRC_INIT=16'hFFFF, CRC_POLY=16'hA001 and CRC_RESIDUAL=16'hB001.
REQ-038 The byte-wise CRC16 next-state function SHALL be a combinational sub-module usb_crc16_byte (crc_in, byte_in -> crc_out).

Verification
REQ-039 Zero-length DATA0: bytes C3 00 00 -> no data_valid; pkt_done with pkt_len=0, crc_ok=1, pkt_err=0, pid=0011.
REQ-040 DATA1 with payload 00 01 02 03 plus golden-model CRC -> four data_valid strobes in order 00..03; pkt_len=4, crc_ok=1. The same packet with a corrupted CRC byte -> crc_ok=0, pkt_err=0.
REQ-041 Bad PID byte C4 -> pkt_err=1, crc_ok=0, no data_valid, a single pkt_done after rx_active falls.
REQ-042 ACK D2 -> pid=0010, pkt_len=0, crc_ok=1; DATA0 with 65 payload bytes (MAX_PAYLOAD=64) -> pkt_err=1 via DRAIN.
REQ-043 rx_error pulse mid-DATA after 3 bytes -> pkt_err=1, no further data_valid, pkt_done once rx_active falls.
REQ-044 Reset asserted mid-DATA with rx_active held high -> no pkt_done; the next packet, starting after rx_active goes low, is received correctly.
